// File: rtl/mem_arbiter.sv
// Shares one synchronous-read word memory between the fetch and data ports.
// Data wins collisions; a bounded starvation counter forces a fetch grant.
`timescale 1ns/1ps

module mem_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_FETCH,
    OWN_DATA
  } owner_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  owner_t     owner;
  logic [3:0] starve_cnt;
  logic       grant_f;
  logic       grant_d;
  logic       starved;

  assign starved = (starve_cnt == STARVE_LIMIT);

  // Grants are forced low while reset is held so nothing reaches the memory.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (d_req && !(i_req && starved)) begin
        grant_d = 1'b1;
      end else if (i_req) begin
        grant_f = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (grant_d) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (grant_f) begin
      m_en   = 1'b1;
      m_addr = i_addr;
    end
  end

  assign i_gnt = grant_f;
  assign d_gnt = grant_d;

  // The owner tag steers the next cycle's memory word back to the issuing port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner      <= OWN_NONE;
      starve_cnt <= 4'd0;
    end else begin
      if (grant_f) begin
        owner <= OWN_FETCH;
      end else if (grant_d && !d_we) begin
        owner <= OWN_DATA;
      end else begin
        owner <= OWN_NONE;
      end

      if (grant_f || !i_req) begin
        starve_cnt <= 4'd0;
      end else if (grant_d && !starved) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign i_rvalid = (owner == OWN_FETCH);
  assign d_rvalid = (owner == OWN_DATA);
  assign i_rdata  = i_rvalid ? m_rdata : '0;
  assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected read
// returns, an independent monitor pops them when rvalid is due.
`timescale 1ns/1ps

module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  logic [31:0] mem [64];
  logic [31:0] model [64];
  logic        mem_loaded = 1'b0;
  exp_t        i_q[$];
  exp_t        d_q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  function automatic logic [31:0] preload(input int k);
    case (k)
      0: return 32'hEB000000;
      1: return 32'hE2800008;
      2: return 32'hE0411001;
      3: return 32'hE2400008;
      default: return 32'hA5000000 + 32'(k);
    endcase
  endfunction

  // Synchronous-read word memory behind the arbiter.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int k = 0; k < 64; k++) mem[k] <= preload(k);
      mem_loaded <= 1'b1;
    end else if (m_en) begin
      if (m_we) mem[m_addr[7:2]] <= m_wdata;
      else m_rdata <= mem[m_addr[7:2]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: compares every cycle's return path against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    logic iv_exp, dv_exp;
    while (i_q.size() > 0 && i_q[0].due < cyc) begin
      checkOutput("i_rvalid missed", 32'd0, 32'd1);
      e = i_q.pop_front();
    end
    while (d_q.size() > 0 && d_q[0].due < cyc) begin
      checkOutput("d_rvalid missed", 32'd0, 32'd1);
      e = d_q.pop_front();
    end
    iv_exp = (i_q.size() > 0) && (i_q[0].due == cyc);
    dv_exp = (d_q.size() > 0) && (d_q[0].due == cyc);
    checkOutput("i_rvalid", {31'd0, i_rvalid}, {31'd0, iv_exp});
    checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, dv_exp});
    if (iv_exp) begin
      e = i_q.pop_front();
      checkOutput("i_rdata", i_rdata, e.data);
    end else begin
      checkOutput("i_rdata idle", i_rdata, 32'd0);
    end
    if (dv_exp) begin
      e = d_q.pop_front();
      checkOutput("d_rdata", d_rdata, e.data);
    end else begin
      checkOutput("d_rdata idle", d_rdata, 32'd0);
    end
  end

  task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd, input logic eig, input logic edg);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    @(negedge clk);
    checkOutput("i_gnt", {31'd0, i_gnt}, {31'd0, eig});
    checkOutput("d_gnt", {31'd0, d_gnt}, {31'd0, edg});
    if (eig) begin
      checkOutput("m_en fetch", {31'd0, m_en}, 32'd1);
      checkOutput("m_we fetch", {31'd0, m_we}, 32'd0);
      checkOutput("m_addr fetch", m_addr, ia);
      checkOutput("m_wdata fetch", m_wdata, 32'd0);
      i_q.push_back('{cyc + 1, model[ia[7:2]]});
    end else if (edg) begin
      checkOutput("m_en data", {31'd0, m_en}, 32'd1);
      checkOutput("m_we data", {31'd0, m_we}, {31'd0, dw});
      checkOutput("m_addr data", m_addr, da);
      checkOutput("m_wdata data", m_wdata, dwd);
      if (dw) model[da[7:2]] = dwd;
      else d_q.push_back('{cyc + 1, model[da[7:2]]});
    end else begin
      checkOutput("m_en idle", {31'd0, m_en}, 32'd0);
      checkOutput("m_we idle", {31'd0, m_we}, 32'd0);
      checkOutput("m_addr idle", m_addr, 32'd0);
    end
  endtask

  task automatic checkAllZero(input string nm);
    checkOutput({nm, " i_gnt"}, {31'd0, i_gnt}, 32'd0);
    checkOutput({nm, " d_gnt"}, {31'd0, d_gnt}, 32'd0);
    checkOutput({nm, " m_en"}, {31'd0, m_en}, 32'd0);
    checkOutput({nm, " m_we"}, {31'd0, m_we}, 32'd0);
    checkOutput({nm, " m_addr"}, m_addr, 32'd0);
    checkOutput({nm, " m_wdata"}, m_wdata, 32'd0);
    checkOutput({nm, " i_rvalid"}, {31'd0, i_rvalid}, 32'd0);
    checkOutput({nm, " d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    checkOutput({nm, " i_rdata"}, i_rdata, 32'd0);
    checkOutput({nm, " d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    logic [31:0] ia, da;
    logic        exp_f;
    for (int k = 0; k < 64; k++) model[k] = preload(k);

    // Outputs must stay quiet under reset even with both ports requesting.
    i_req = 1'b1; i_addr = 32'h4; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h10; d_wdata = 32'h12345678;
    #2;
    checkAllZero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;

    $display("[TB] fetch only");
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] collision");
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] starvation");
    ia = 32'h0;
    da = 32'h10;
    for (int k = 0; k < 14; k++) begin
      exp_f = ((k % 5) == 4);
      applyStimulus(1'b1, ia, 1'b1, 1'b0, da, 32'h0, exp_f, !exp_f);
      checkOutput("starve_cnt bound", {31'd0, (dut.starve_cnt <= 4'd4)}, 32'd1);
      if (exp_f) ia = ia + 32'h4;
      else da = da + 32'h4;
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] store then load");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fetch granted, then reset lands before the edge that would launch its return.
    $display("[TB] reset mid-read");
    @(posedge clk);
    #1;
    i_req = 1'b1; i_addr = 32'h4;
    #1;
    checkOutput("pre-reset i_gnt", {31'd0, i_gnt}, 32'd1);
    #2;
    reset = 1'b1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
    #1;
    checkAllZero("mid-read reset");
    @(posedge clk);
    #1;
    checkAllZero("held reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #1;
    checkOutput("post-reset i_gnt", {31'd0, i_gnt}, 32'd1);
    i_q.push_back('{cyc + 1, model[1]});
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    $display("[TB] idle");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("idle starve_cnt", {28'd0, dut.starve_cnt}, 32'd0);
    end

    @(negedge clk);
    #1;
    checkOutput("i_q drained", i_q.size(), 32'd0);
    checkOutput("d_q drained", d_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
